// File: rtl/string_ram_writer.sv
// Renders ASCII characters into a column-organised string RAM (one word per glyph column).
// Glyph columns come from a synchronous font ROM with a one-cycle read latency.
module string_ram_writer #(
    parameter  int CHAR_W    = 8,
    parameter  int CHAR_H    = 16,
    parameter  int MAX_CHARS = 32,
    localparam int DEPTH     = MAX_CHARS * CHAR_W,
    localparam int AW        = $clog2(DEPTH),
    localparam int CW        = $clog2(CHAR_W),
    localparam int NW        = $clog2(MAX_CHARS + 1)
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              clear_i,
    input  logic [7:0]        char_i,
    input  logic              char_valid_i,
    output logic              char_ready_o,
    output logic [8+CW-1:0]   font_addr_o,
    input  logic [CHAR_H-1:0] font_data_i,
    output logic              wr_en_o,
    output logic [AW-1:0]     wr_addr_o,
    output logic [CHAR_H-1:0] wr_data_o,
    output logic [NW-1:0]     cursor_o,
    output logic              full_o,
    output logic              busy_o
);

    typedef enum logic [1:0] {
        S_CLEAR,
        S_IDLE,
        S_RENDER,
        S_DRAIN
    } state_t;

    state_t              r_state;
    logic [AW-1:0]       r_clr_cnt;
    logic [NW-1:0]       r_cursor;
    logic                r_clear_pending;
    logic [7:0]          r_char;
    logic [CW-1:0]       r_col;
    logic                r_p1_vld;
    logic [CW-1:0]       r_p1_col;
    logic                r_wr_en;
    logic [AW-1:0]       r_wr_addr;
    logic [CHAR_H-1:0]   r_wr_data;

    logic                w_full;
    logic                w_ready;
    logic [AW-1:0]       w_render_addr;

    assign w_full        = (r_cursor == NW'(MAX_CHARS));
    assign w_ready       = (r_state == S_IDLE) && !w_full && !r_clear_pending && !clear_i;
    // Column of the ROM word arriving this cycle, placed at the current character slot.
    assign w_render_addr = AW'(r_cursor * CHAR_W) + AW'(r_p1_col);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state         <= S_CLEAR;
            r_clr_cnt       <= '0;
            r_cursor        <= '0;
            r_clear_pending <= 1'b0;
            r_char          <= '0;
            r_col           <= '0;
            r_p1_vld        <= 1'b0;
            r_p1_col        <= '0;
            r_wr_en         <= 1'b0;
            r_wr_addr       <= '0;
            r_wr_data       <= '0;
        end else begin
            // NOTE: defaults first, later non-blocking assignments in this block override them.
            r_wr_en  <= 1'b0;
            r_p1_vld <= 1'b0;
            if (clear_i) begin
                r_clear_pending <= 1'b1;
            end

            case (r_state)
                S_CLEAR: begin
                    r_wr_en   <= 1'b1;
                    r_wr_addr <= r_clr_cnt;
                    r_wr_data <= '0;
                    if (r_clr_cnt == AW'(DEPTH - 1)) begin
                        r_state   <= S_IDLE;
                        r_cursor  <= '0;
                        r_clr_cnt <= '0;
                    end else begin
                        r_clr_cnt <= r_clr_cnt + 1'b1;
                    end
                end
                S_IDLE: begin
                    // A request seen here is consumed; one arriving during the sweep re-arms it.
                    if (r_clear_pending || clear_i) begin
                        r_state         <= S_CLEAR;
                        r_clr_cnt       <= '0;
                        r_clear_pending <= 1'b0;
                    end else if (char_valid_i && !w_full) begin
                        r_state <= S_RENDER;
                        r_char  <= char_i;
                        r_col   <= '0;
                    end
                end
                S_RENDER: begin
                    r_p1_vld <= 1'b1;
                    r_p1_col <= r_col;
                    if (r_col == CW'(CHAR_W - 1)) begin
                        r_state <= S_DRAIN;
                    end else begin
                        r_col <= r_col + 1'b1;
                    end
                end
                S_DRAIN: begin
                    r_state  <= S_IDLE;
                    r_cursor <= r_cursor + 1'b1;
                end
                default: r_state <= S_CLEAR;
            endcase

            if (r_p1_vld) begin
                r_wr_en   <= 1'b1;
                r_wr_addr <= w_render_addr;
                r_wr_data <= font_data_i;
            end
        end
    end

    assign char_ready_o = w_ready;
    assign font_addr_o  = {r_char, r_col};
    assign wr_en_o      = r_wr_en;
    assign wr_addr_o    = r_wr_addr;
    assign wr_data_o    = r_wr_data;
    assign cursor_o     = r_cursor;
    assign full_o       = w_full;
    assign busy_o       = (r_state != S_IDLE);

endmodule
